// File: rtl/pll_reset_ctrl.sv
// pll_reset_ctrl: sequences the ECP5 PLL reset and derives a lock-qualified system reset.
// Clocked from the board oscillator so it keeps running while the PLL output is dead.
module pll_reset_ctrl #(
    parameter int SYNC_STAGES         = 2,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 1048576,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_ATTEMPTS        = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       locked_i,
    output logic       pll_rst_o,
    output logic       sys_reset_n_o,
    output logic       ready_o,
    output logic       fault_o,
    output logic [7:0] lock_loss_count_o
);

    localparam int T01 = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                         PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int TMAX = (T01 > LOCK_STABLE_CYCLES) ? T01 : LOCK_STABLE_CYCLES;
    localparam int TW = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int AW = (MAX_ATTEMPTS > 1) ? $clog2(MAX_ATTEMPTS + 1) : 1;

    localparam logic [TW-1:0] RST_LAST = TW'(PLL_RST_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] STB_LAST = TW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [AW-1:0] ATT_LAST = (MAX_ATTEMPTS > 0) ?
                                         AW'(MAX_ATTEMPTS - 1) : '0;

    typedef enum logic [2:0] {
        ST_PLL_RESET,
        ST_WAIT_LOCK,
        ST_STABILIZE,
        ST_RUN,
        ST_FAULT
    } state_e;

    state_e                 state_q, state_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [AW-1:0]          attempt_q, attempt_d;
    logic [7:0]             loss_q, loss_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   pll_rst_q, pll_rst_d;
    logic                   sys_rst_n_q, sys_rst_n_d;
    logic                   ready_q, ready_d;
    logic                   fault_q, fault_d;
    logic                   locked_s;
    logic                   last_attempt;

    assign locked_s = sync_q[SYNC_STAGES-1];

    // A shared timer is safe: every transition restarts it from zero.
    assign last_attempt = (MAX_ATTEMPTS != 0) && (attempt_q == ATT_LAST);

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], locked_i};
        state_d   = state_q;
        timer_d   = timer_q;
        attempt_d = attempt_q;
        loss_d    = loss_q;

        unique case (state_q)
            ST_PLL_RESET: begin
                if (timer_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = ST_STABILIZE;
                    timer_d = '0;
                end else if (timer_q == TMO_LAST) begin
                    timer_d = '0;
                    if (MAX_ATTEMPTS != 0) begin
                        attempt_d = attempt_q + AW'(1);
                    end
                    state_d = last_attempt ? ST_FAULT : ST_PLL_RESET;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_STABILIZE: begin
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                    timer_d = '0;
                end else if (timer_q == STB_LAST) begin
                    state_d   = ST_RUN;
                    timer_d   = '0;
                    attempt_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_RUN: begin
                if (!locked_s) begin
                    state_d = ST_PLL_RESET;
                    timer_d = '0;
                    if (loss_q != 8'hFF) begin
                        loss_d = loss_q + 8'd1;
                    end
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_PLL_RESET;
                timer_d = '0;
            end
        endcase

        // Outputs decoded from the next state so they move with the state.
        pll_rst_d   = (state_d == ST_PLL_RESET);
        sys_rst_n_d = (state_d == ST_RUN);
        ready_d     = (state_d == ST_RUN);
        fault_d     = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_PLL_RESET;
            timer_q     <= '0;
            attempt_q   <= '0;
            loss_q      <= '0;
            sync_q      <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            attempt_q   <= attempt_d;
            loss_q      <= loss_d;
            sync_q      <= sync_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_n_q <= sys_rst_n_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
        end
    end

    assign pll_rst_o         = pll_rst_q;
    assign sys_reset_n_o     = sys_rst_n_q;
    assign ready_o           = ready_q;
    assign fault_o           = fault_q;
    assign lock_loss_count_o = loss_q;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// tb_pll_reset_ctrl: scoreboard bench for pll_reset_ctrl.
// Expected outputs are queued with the edge count at which they must appear.
module tb_pll_reset_ctrl;

    logic       clk;
    logic       clk_run;
    logic       reset_n;
    logic       locked_i;
    logic       pll_rst_o;
    logic       sys_reset_n_o;
    logic       ready_o;
    logic       fault_o;
    logic [7:0] lock_loss_count_o;
    logic [11:0] outs;

    int edges;
    int n_cmp;
    int n_bad;

    typedef struct {
        int          at;
        string       tag;
        logic [11:0] val;
    } exp_t;

    exp_t sb[$];

    pll_reset_ctrl #(
        .SYNC_STAGES        (2),
        .PLL_RST_CYCLES     (4),
        .LOCK_TIMEOUT_CYCLES(32),
        .LOCK_STABLE_CYCLES (8),
        .MAX_ATTEMPTS       (2)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .locked_i         (locked_i),
        .pll_rst_o        (pll_rst_o),
        .sys_reset_n_o    (sys_reset_n_o),
        .ready_o          (ready_o),
        .fault_o          (fault_o),
        .lock_loss_count_o(lock_loss_count_o)
    );

    assign outs = {pll_rst_o, sys_reset_n_o, ready_o, fault_o, lock_loss_count_o};

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    always @(posedge clk) edges <= edges + 1;

    function automatic logic [11:0] pat(input logic p, input logic s,
                                        input logic r, input logic f,
                                        input logic [7:0] c);
        return {p, s, r, f, c};
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (edge %0d)", tag, got, want, edges);
        end
    endtask

    task automatic expect_at(input int dt, input string tag, input logic [11:0] v);
        exp_t e;
        e.at  = edges + dt;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == edges) begin
                check(sb[i].tag, {20'd0, outs}, {20'd0, sb[i].val});
                sb.delete(i);
            end else if (sb[i].at < edges) begin
                check({sb[i].tag, "_missed"}, edges, sb[i].at);
                sb.delete(i);
            end
        end
    endtask

    task automatic wait_edges(input int n);
        repeat (n) begin
            @(negedge clk);
            drain();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] cnt;
        edges    = 0;
        n_cmp    = 0;
        n_bad    = 0;
        clk_run  = 1'b1;
        reset_n  = 1'b0;
        locked_i = 1'b0;

        wait_edges(3);
        check("reset", {20'd0, outs}, {20'd0, pat(1, 0, 0, 0, 0)});

        // bring-up
        reset_n = 1'b1;
        expect_at(1, "s1_prst_a", pat(1, 0, 0, 0, 0));
        expect_at(3, "s1_prst_b", pat(1, 0, 0, 0, 0));
        expect_at(4, "s1_prst_off", pat(0, 0, 0, 0, 0));
        wait_edges(10);
        locked_i = 1'b1;
        expect_at(10, "s1_hold", pat(0, 0, 0, 0, 0));
        expect_at(11, "s1_run", pat(0, 1, 1, 0, 0));
        wait_edges(14);

        // loss in RUN
        locked_i = 1'b0;
        expect_at(2, "s4_still_run", pat(0, 1, 1, 0, 0));
        expect_at(3, "s4_drop", pat(1, 0, 0, 0, 1));
        expect_at(6, "s4_prst_end", pat(1, 0, 0, 0, 1));
        expect_at(7, "s4_prst_off", pat(0, 0, 0, 0, 1));
        wait_edges(8);

        // relock with a glitch during stabilise
        locked_i = 1'b1;
        for (int i = 4; i < 20; i++) expect_at(i, "s2_no_pulse", pat(0, 0, 0, 0, 1));
        expect_at(20, "s2_run", pat(0, 1, 1, 0, 1));
        wait_edges(6);
        locked_i = 1'b0;
        wait_edges(3);
        locked_i = 1'b1;
        wait_edges(14);

        // saturation
        cnt = 8'd1;
        for (int n = 0; n < 260; n++) begin
            locked_i = 1'b0;
            if (cnt != 8'hFF) cnt = cnt + 8'd1;
            expect_at(3, "s5_drop", pat(1, 0, 0, 0, cnt));
            wait_edges(8);
            locked_i = 1'b1;
            expect_at(11, "s5_run", pat(0, 1, 1, 0, cnt));
            wait_edges(12);
        end
        check("s5_sat", {24'd0, lock_loss_count_o}, 32'd255);

        // async reset while in STABILIZE with clock stopped
        locked_i = 1'b0;
        wait_edges(8);
        locked_i = 1'b1;
        expect_at(5, "s6_stab", pat(0, 0, 0, 0, 8'hFF));
        wait_edges(6);
        clk_run = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        check("s6_async", {20'd0, outs}, {20'd0, pat(1, 0, 0, 0, 0)});
        #5;
        clk_run  = 1'b1;
        locked_i = 1'b0;
        wait_edges(3);

        // lock timeout to FAULT
        reset_n = 1'b1;
        expect_at(35, "s3_wait1", pat(0, 0, 0, 0, 0));
        expect_at(36, "s3_retry", pat(1, 0, 0, 0, 0));
        expect_at(39, "s3_retry_end", pat(1, 0, 0, 0, 0));
        expect_at(40, "s3_wait2", pat(0, 0, 0, 0, 0));
        expect_at(71, "s3_wait2_end", pat(0, 0, 0, 0, 0));
        expect_at(72, "s3_fault", pat(0, 0, 0, 1, 0));
        wait_edges(75);
        locked_i = 1'b1;
        expect_at(20, "s3_stuck", pat(0, 0, 0, 1, 0));
        wait_edges(22);
        reset_n = 1'b0;
        #1;
        check("s3_fault_clr", {20'd0, outs}, {20'd0, pat(1, 0, 0, 0, 0)});

        check("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
